// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: filters PLL lock and releases per-domain resets one at a time
`timescale 1ns/1ps
module pll_reset_sequencer #(
    parameter int NUM_DOMAINS  = 4,
    parameter int LOCK_FILTER  = 8,
    parameter int STAGE_CYCLES = 16,
    parameter int CNT_W        = 8
) (
    input  logic                   pll_clock,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   all_ready,
    output logic [1:0]             seq_state,
    output logic [CNT_W-1:0]       relock_count
);
    localparam int LW = $clog2(LOCK_FILTER + 1);
    localparam int SW = $clog2(STAGE_CYCLES + 1);
    localparam int IW = $clog2(NUM_DOMAINS + 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FILTER - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {HOLD = 2'd0, RELEASE = 2'd1, RUN = 2'd2} state_t;

    state_t                 state, state_d;
    logic                   sync_q1, locked_s;
    logic                   abort;
    logic [LW-1:0]          lock_cnt, lock_cnt_d;
    logic [SW-1:0]          stage_cnt, stage_cnt_d;
    logic [IW-1:0]          stage_idx, stage_idx_d;
    logic [NUM_DOMAINS-1:0] domain_rst_d;
    logic                   all_ready_d;
    logic [CNT_W-1:0]       relock_d;

    assign seq_state = state;

    // two-flop synchronizer bringing pll_locked into the pll_clock domain
    always_ff @(posedge pll_clock or posedge reset) begin
        if (reset) begin
            sync_q1  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q1  <= pll_locked;
            locked_s <= sync_q1;
        end
    end

    // sequencer state, counters and registered outputs
    always_ff @(posedge pll_clock or posedge reset) begin
        if (reset) begin
            state        <= HOLD;
            lock_cnt     <= '0;
            stage_cnt    <= '0;
            stage_idx    <= '0;
            domain_rst   <= '1;
            all_ready    <= 1'b0;
            relock_count <= '0;
        end else begin
            state        <= state_d;
            lock_cnt     <= lock_cnt_d;
            stage_cnt    <= stage_cnt_d;
            stage_idx    <= stage_idx_d;
            domain_rst   <= domain_rst_d;
            all_ready    <= all_ready_d;
            relock_count <= relock_d;
        end
    end

    // next state: abort wins over everything, then lock filtering or staged release
    always_comb begin
        state_d      = state;
        lock_cnt_d   = lock_cnt;
        stage_cnt_d  = stage_cnt;
        stage_idx_d  = stage_idx;
        domain_rst_d = domain_rst;
        all_ready_d  = all_ready;
        relock_d     = relock_count;
        abort        = (state != HOLD) && (!locked_s || sw_reset_req);
        if (abort) begin
            state_d      = HOLD;
            lock_cnt_d   = '0;
            stage_cnt_d  = '0;
            stage_idx_d  = '0;
            domain_rst_d = '1;
            all_ready_d  = 1'b0;
            if (state == RUN && !locked_s && relock_count != '1)
                relock_d = relock_count + CNT_W'(1);
        end else if (state == HOLD) begin
            domain_rst_d = '1;
            all_ready_d  = 1'b0;
            if (!locked_s) begin
                lock_cnt_d = '0;
            end else if (lock_cnt == LOCK_LAST) begin
                state_d     = RELEASE;
                lock_cnt_d  = '0;
                stage_cnt_d = '0;
                stage_idx_d = '0;
            end else begin
                lock_cnt_d = lock_cnt + LW'(1);
            end
        end else if (state == RELEASE) begin
            if (stage_cnt == STAGE_LAST) begin
                domain_rst_d = domain_rst & ~(NUM_DOMAINS'(1) << stage_idx);
                stage_cnt_d  = '0;
                stage_idx_d  = stage_idx + IW'(1);
                if (stage_idx == IDX_LAST) begin
                    state_d     = RUN;
                    all_ready_d = 1'b1;
                end
            end else begin
                stage_cnt_d = stage_cnt + SW'(1);
            end
        end else if (state != RUN) begin
            state_d      = HOLD;
            domain_rst_d = '1;
            all_ready_d  = 1'b0;
        end
    end
endmodule
